// File: rtl/da_fir_engine.sv
// Bit-serial distributed-arithmetic FIR engine.
// Each accepted sample is pushed into an NTAPS-deep delay line. The engine then spends DW
// cycles processing one bit-plane per cycle. In each of those cycles, NPART partial-sum LUTs
// are addressed by the current bit of their K taps. The sign plane is subtracted.
// LUT contents survive reset so software only reloads coefficients when they change.
module da_fir_engine #(
  parameter int DW    = 8,
  parameter int K     = 4,
  parameter int NPART = 4,
  parameter int CW    = 20,
  localparam int ACCW = CW + DW + $clog2(NPART),
  localparam int AW   = $clog2(NPART) + K
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [ACCW-1:0] out_data,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [CW-1:0]   cfg_data,
  output logic            cfg_err
);

  localparam int NTAPS = NPART * K;
  localparam int DEPTH = NPART * (2 ** K);
  localparam int BW    = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state, state_next;
  logic [BW-1:0]          bit_cnt;
  logic signed [ACCW-1:0] acc, acc_next, psum, term;
  logic [DW-1:0]          taps [NTAPS];
  logic signed [CW-1:0]   lut [DEPTH];
  logic [K-1:0]           lut_sel;
  logic [AW-1:0]          lut_idx;
  logic                   accept;

  assign accept = in_valid && in_ready;

  // Next-state and handshake decode; ready whenever no bit-plane is in flight.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (bit_cnt == LAST_BIT) state_next = DONE;
      end
      DONE: begin
        in_ready   = 1'b1;
        out_valid  = 1'b1;
        state_next = in_valid ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Partial sum of the current bit-plane across all partitions, and the accumulator update.
  // The last plane carries the sample sign weight and is therefore subtracted.
  always_comb begin
    psum    = '0;
    lut_sel = '0;
    lut_idx = '0;
    for (int p = 0; p < NPART; p++) begin
      for (int k = 0; k < K; k++) begin
        lut_sel[k] = taps[p*K+k][bit_cnt];
      end
      lut_idx = AW'(p * (2 ** K)) + AW'(lut_sel);
      psum    = psum + ACCW'(lut[lut_idx]);
    end
    term     = psum << bit_cnt;
    acc_next = (bit_cnt == LAST_BIT) ? (acc - term) : (acc + term);
  end

  // Datapath and FSM state: delay line, bit counter, accumulator, output register, error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      acc      <= '0;
      out_data <= '0;
      cfg_err  <= 1'b0;
      for (int i = 0; i < NTAPS; i++) taps[i] <= '0;
    end else begin
      state   <= state_next;
      cfg_err <= cfg_we && (state == SHIFT);
      if (accept) begin
        for (int i = NTAPS - 1; i > 0; i--) taps[i] <= taps[i-1];
        taps[0] <= in_data;
        bit_cnt <= '0;
        acc     <= '0;
      end else if (state == SHIFT) begin
        acc     <= acc_next;
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == LAST_BIT) out_data <= acc_next;
      end
    end
  end

  // LUT storage has no reset; writes are refused while a bit-plane walk is reading it.
  always_ff @(posedge clk) begin
    if (cfg_we && (state != SHIFT)) lut[cfg_addr] <= cfg_data;
  end

endmodule

// File: tb/tb_da_fir_engine.sv
// Self-checking bench for da_fir_engine: integer convolution model plus directed literals.
module tb_da_fir_engine;

  localparam int DW    = 8;
  localparam int K     = 4;
  localparam int NPART = 4;
  localparam int CW    = 20;
  localparam int ACCW  = 30;
  localparam int NTAPS = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            in_ready;
  logic            out_valid;
  logic [ACCW-1:0] out_data;
  logic            cfg_we = 1'b0;
  logic [5:0]      cfg_addr = '0;
  logic [CW-1:0]   cfg_data = '0;
  logic            cfg_err;

  da_fir_engine dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { longint val; int cyc; } exp_t;
  exp_t   expq[$];
  longint outlog[$];
  longint coef [NTAPS];
  longint hist [NTAPS];
  int     checks = 0;
  int     failures = 0;

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  // Every output pulse must match the oldest outstanding model result, 9 cycles after acceptance.
  initial begin
    exp_t   e;
    longint got;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        got = longint'($signed(out_data));
        outlog.push_back(got);
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out_valid got=%0d expected=none", got);
        end else begin
          e = expq.pop_front();
          check("out_data_model", got, e.val);
          check("latency", longint'(cyc - e.cyc), 9);
        end
      end
    end
  end

  task automatic clear_model();
    expq.delete();
    for (int i = 0; i < NTAPS; i++) hist[i] = 0;
  endtask

  task automatic push(input longint x);
    int n;
    longint y;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = DW'(x);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      for (int i = NTAPS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = x;
      y = 0;
      for (int i = 0; i < NTAPS; i++) y += coef[i] * hist[i];
      expq.push_back('{y, cyc});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0) check("drain_timeout", longint'(expq.size()), 0);
    @(negedge clk);
  endtask

  task automatic load_lut();
    longint s;
    for (int p = 0; p < NPART; p++) begin
      for (int e = 0; e < 16; e++) begin
        s = 0;
        for (int k = 0; k < K; k++) if (((e >> k) & 1) != 0) s += coef[p*K+k];
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = 6'(p * 16 + e);
        cfg_data = CW'(s);
      end
    end
    @(negedge clk);
    cfg_we = 1'b0;
    @(negedge clk);
    check("cfg_err_after_load", longint'(cfg_err), 0);
  endtask

  initial begin
    clear_model();
    for (int i = 0; i < NTAPS; i++) coef[i] = 0;

    // Reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_in_ready", longint'(in_ready), 1);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_out_data", longint'(out_data), 0);
    check("reset_cfg_err", longint'(cfg_err), 0);
    reset = 1'b0;

    // Impulse response with c_i = i+1, back-to-back samples
    for (int i = 0; i < NTAPS; i++) coef[i] = i + 1;
    load_lut();
    outlog.delete();
    push(1);
    for (int i = 0; i < 16; i++) push(0);
    drain();
    check("impulse_count", longint'(outlog.size()), 17);
    if (outlog.size() == 17) begin
      for (int i = 0; i < 16; i++) check("impulse_literal", outlog[i], longint'(i + 1));
      check("impulse_tail", outlog[16], 0);
    end

    // Sign plane with only c_0 = 1000
    for (int i = 0; i < NTAPS; i++) coef[i] = 0;
    coef[0] = 1000;
    load_lut();
    outlog.delete();
    push(-128);
    push(127);
    drain();
    check("sign_count", longint'(outlog.size()), 2);
    if (outlog.size() == 2) begin
      check("sign_neg128", outlog[0], -128000);
      check("sign_pos127", outlog[1], 127000);
    end

    // Configuration write during SHIFT bit 3 must be refused
    outlog.delete();
    push(50);
    repeat (4) @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = CW'(5);
    @(posedge clk);
    #1 cfg_we = 1'b0;
    @(negedge clk);
    check("cfg_err_pulse", longint'(cfg_err), 1);
    @(negedge clk);
    check("cfg_err_one_cycle", longint'(cfg_err), 0);
    drain();
    push(3);
    drain();
    check("collision_count", longint'(outlog.size()), 2);
    if (outlog.size() == 2) begin
      check("collision_result", outlog[0], 50000);
      check("collision_after", outlog[1], 3000);
    end

    // Reset at SHIFT bit 4 abandons the computation and clears the delay line
    for (int i = 0; i < NTAPS; i++) coef[i] = i + 1;
    load_lut();
    outlog.delete();
    push(7);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("reset_midop_no_output", longint'(outlog.size()), 0);
    push(1);
    push(0);
    push(0);
    drain();
    check("post_reset_count", longint'(outlog.size()), 3);
    if (outlog.size() == 3) begin
      check("post_reset_y0", outlog[0], 1);
      check("post_reset_y1", outlog[1], 2);
      check("post_reset_y2", outlog[2], 3);
    end

    // Random coefficients and samples against the convolution model
    for (int i = 0; i < NTAPS; i++) coef[i] = longint'($urandom_range(0, 200000)) - 100000;
    load_lut();
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      push(longint'($urandom_range(0, 255)) - 128);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
